// File: rtl/pc_next_unit.sv
// Program-counter stage ahead of the instruction memory: holds the PC, chooses the next PC,
// rejects out-of-window or misaligned targets with a sticky fault, and counts committed updates.
module pc_next_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          ADR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] upd_count
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    localparam logic [31:0] WIN_BYTES = 32'd4 << ADR_BITS;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fault_pc;
    logic [31:0] r_upd_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic [31:0] w_win_off;
    logic        w_npc_valid;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;
    assign w_br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        // NOTE: default first so every path assigns w_npc and no latch is inferred.
        w_npc = w_pc_plus4;
        case (npc_sel)
            2'b01:   if (br_taken) w_npc = w_pc_plus4 + w_br_off;
            2'b10:   w_npc = {w_pc_plus4[31:28], instr_index, 2'b00};
            2'b11:   w_npc = jr_target;
            default: w_npc = w_pc_plus4;
        endcase
    end

    // Unsigned difference: targets below the base wrap high and fail the window test.
    assign w_win_off   = w_npc - PC_RESET;
    assign w_npc_valid = (w_npc[1:0] == 2'b00) && (w_win_off < WIN_BYTES);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= S_RUN;
            r_pc        <= PC_RESET;
            r_fault_pc  <= 32'd0;
            r_upd_count <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!stall) begin
                        if (w_npc_valid) begin
                            r_pc        <= w_npc;
                            r_upd_count <= r_upd_count + 32'd1;
                        end else begin
                            r_fault_pc <= w_npc;
                            r_state    <= S_FAULT;
                        end
                    end
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign pc_plus8  = w_pc_plus8;
    assign fault     = (r_state == S_FAULT);
    assign fault_pc  = r_fault_pc;
    assign upd_count = r_upd_count;

endmodule
